// File: rtl/alu_muldiv_seq.sv
// Iterative 32x32 unsigned multiply / 32/32 unsigned divide sequencer.
// Borrows the shared execute-stage ALU one step per granted cycle.
// Multiply: shift-add over a 65-bit {carry,hi,lo} accumulator.
// Divide: restoring division, where each step is one ALU subtract.
module alu_muldiv_seq #(
   parameter logic [31:0] DIVZERO_Q = 32'hFFFFFFFF,
   parameter int unsigned ITERS     = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_valid,
   output logic        start_ready,
   input  logic        start_op,
   input  logic [31:0] start_a,
   input  logic [31:0] start_b,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        res_dz,
   output logic        alu_req,
   input  logic        alu_gnt,
   output logic [3:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic        alu_cin,
   input  logic [31:0] alu_y,
   input  logic [3:0]  alu_flags
);

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 6;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0010;

   // acc: product high half / partial remainder
   // sh : multiplier being shifted out / quotient being shifted in
   // opnd: multiplicand / divisor
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          op_q, op_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [W-1:0]  sh_q, sh_d;
   logic [W-1:0]  opnd_q, opnd_d;
   logic [W-1:0]  res_hi_q, res_hi_d;
   logic [W-1:0]  res_lo_q, res_lo_d;
   logic          res_dz_q, res_dz_d;
   logic          start_ready_q, start_ready_d;
   logic          res_valid_q, res_valid_d;
   logic          alu_req_q, alu_req_d;
   logic [3:0]    alu_op_q, alu_op_d;
   logic [W-1:0]  alu_a_q, alu_a_d;
   logic [W-1:0]  alu_b_q, alu_b_d;

   logic          carry;
   logic [W-1:0]  div_t;
   logic          unused_flags;

   assign carry        = alu_flags[1];
   assign div_t        = {acc_q[W-2:0], sh_q[W-1]};
   assign unused_flags = ^{alu_flags[3:2], alu_flags[0]};

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      acc_d    = acc_q;
      sh_d     = sh_q;
      opnd_d   = opnd_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      res_dz_d = res_dz_q;

      case (state_q)
         S_IDLE: begin
            if (start_valid) begin
               op_d     = start_op;
               res_dz_d = 1'b0;
               if (start_op && (start_b == '0)) begin
                  state_d  = S_DONE;
                  res_lo_d = DIVZERO_Q;
                  res_hi_d = start_a;
                  res_dz_d = 1'b1;
               end else begin
                  state_d = S_CALC;
                  cnt_d   = '0;
                  acc_d   = '0;
                  sh_d    = start_op ? start_a : start_b;
                  opnd_d  = start_op ? start_b : start_a;
               end
            end
         end
         S_CALC: begin
            if (alu_gnt) begin
               if (op_q) begin
                  // Subtract succeeds when the 33-bit trial value >= divisor
                  if (acc_q[W-1] || !carry) begin
                     acc_d = alu_y;
                     sh_d  = {sh_q[W-2:0], 1'b1};
                  end else begin
                     acc_d = div_t;
                     sh_d  = {sh_q[W-2:0], 1'b0};
                  end
               end else begin
                  acc_d = {carry, alu_y[W-1:1]};
                  sh_d  = {alu_y[0], sh_q[W-1:1]};
               end
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(ITERS - 1)) begin
                  state_d  = S_DONE;
                  res_hi_d = acc_d;
                  res_lo_d = sh_d;
               end
            end
         end
         S_DONE: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      start_ready_d = (state_d == S_IDLE);
      res_valid_d   = (state_d == S_DONE);
      alu_req_d     = (state_d == S_CALC);
      alu_op_d      = '0;
      alu_a_d       = '0;
      alu_b_d       = '0;
      // ALU operands are registered from the next datapath state, so they
      // always match the registers the next granted edge will update.
      if (state_d == S_CALC) begin
         if (op_d) begin
            alu_op_d = OP_SUB;
            alu_a_d  = {acc_d[W-2:0], sh_d[W-1]};
            alu_b_d  = opnd_d;
         end else begin
            alu_op_d = OP_ADD;
            alu_a_d  = acc_d;
            alu_b_d  = sh_d[0] ? opnd_d : '0;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         op_q          <= 1'b0;
         acc_q         <= '0;
         sh_q          <= '0;
         opnd_q        <= '0;
         res_hi_q      <= '0;
         res_lo_q      <= '0;
         res_dz_q      <= 1'b0;
         start_ready_q <= 1'b1;
         res_valid_q   <= 1'b0;
         alu_req_q     <= 1'b0;
         alu_op_q      <= '0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         op_q          <= op_d;
         acc_q         <= acc_d;
         sh_q          <= sh_d;
         opnd_q        <= opnd_d;
         res_hi_q      <= res_hi_d;
         res_lo_q      <= res_lo_d;
         res_dz_q      <= res_dz_d;
         start_ready_q <= start_ready_d;
         res_valid_q   <= res_valid_d;
         alu_req_q     <= alu_req_d;
         alu_op_q      <= alu_op_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
      end
   end

   assign start_ready = start_ready_q;
   assign res_valid   = res_valid_q;
   assign res_hi      = res_hi_q;
   assign res_lo      = res_lo_q;
   assign res_dz      = res_dz_q;
   assign alu_req     = alu_req_q;
   assign alu_op      = alu_op_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_cin     = 1'b0;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: behavioural shared ALU, scoreboard of
// expected results pushed on accept and popped on result hand-off.
module tb_alu_muldiv_seq;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start_valid;
   logic        start_ready;
   logic        start_op;
   logic [31:0] start_a;
   logic [31:0] start_b;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic        res_dz;
   logic        alu_req;
   logic        alu_gnt;
   logic [3:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic        alu_cin;
   logic [31:0] alu_y;
   logic [3:0]  alu_flags;

   int   n_checks;
   int   n_fail;
   exp_t sb[$];

   alu_muldiv_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .start_op    (start_op),
      .start_a     (start_a),
      .start_b     (start_b),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_hi      (res_hi),
      .res_lo      (res_lo),
      .res_dz      (res_dz),
      .alu_req     (alu_req),
      .alu_gnt     (alu_gnt),
      .alu_op      (alu_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_cin     (alu_cin),
      .alu_y       (alu_y),
      .alu_flags   (alu_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Execute-stage ALU: add (C = carry-out) and subtract (C = a < b)
   always_comb begin
      logic [32:0] sum;
      logic        c;
      logic        v;
      sum   = '0;
      c     = 1'b0;
      v     = 1'b0;
      alu_y = '0;
      case (alu_op)
         4'b0000: begin
            sum   = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
            alu_y = sum[31:0];
            c     = sum[32];
            v     = (alu_a[31] == alu_b[31]) && (alu_y[31] != alu_a[31]);
         end
         4'b0010: begin
            alu_y = alu_a - alu_b;
            c     = (alu_a < alu_b);
            v     = (alu_a[31] != alu_b[31]) && (alu_y[31] != alu_a[31]);
         end
         default: alu_y = '0;
      endcase
      alu_flags = {(alu_y == '0), alu_y[31], c, v};
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_start_ready", 64'(start_ready), 64'd1);
      chk("rst_res_valid",   64'(res_valid),   64'd0);
      chk("rst_res_hi",      64'(res_hi),      64'd0);
      chk("rst_res_lo",      64'(res_lo),      64'd0);
      chk("rst_res_dz",      64'(res_dz),      64'd0);
      chk("rst_alu_req",     64'(alu_req),     64'd0);
      chk("rst_alu_op",      64'(alu_op),      64'd0);
      chk("rst_alu_a",       64'(alu_a),       64'd0);
      chk("rst_alu_b",       64'(alu_b),       64'd0);
      chk("rst_alu_cin",     64'(alu_cin),     64'd0);
   endtask

   // Issue one operation with 'stalls' random grant-low CALC cycles and
   // hold res_ready low for 'rr_hold' cycles once the result is valid.
   task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input int stalls, input int rr_hold);
      exp_t        e;
      logic [63:0] p;
      int          lat;
      int          exp_lat;
      int          rem_st;
      int          granted;
      logic        g;
      logic [31:0] a0;
      logic [31:0] b0;
      logic [31:0] h0;
      logic [31:0] l0;

      if (!op) begin
         p = 64'(a) * 64'(b);
         e = '{hi: p[63:32], lo: p[31:0], dz: 1'b0};
      end else if (b == 32'd0) begin
         e = '{hi: a, lo: 32'hFFFF_FFFF, dz: 1'b1};
      end else begin
         e = '{hi: a % b, lo: a / b, dz: 1'b0};
      end
      exp_lat = (op && b == 32'd0) ? 1 : 33 + stalls;

      @(negedge clk);
      chk("start_ready_idle", 64'(start_ready), 64'd1);
      start_valid = 1'b1;
      start_op    = op;
      start_a     = a;
      start_b     = b;
      alu_gnt     = 1'b1;
      res_ready   = (rr_hold == 0);
      sb.push_back(e);
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      start_op    = ~op;
      start_a     = ~a;
      start_b     = ~b;

      lat     = 1;
      rem_st  = stalls;
      granted = 0;
      while (!res_valid && lat < 200) begin
         chk("alu_req_calc", 64'(alu_req), 64'd1);
         chk("start_ready_calc", 64'(start_ready), 64'd0);
         @(negedge clk);
         g = 1'b1;
         if (rem_st > 0 && (($urandom_range(0, 2) == 0) || granted >= 31)) g = 1'b0;
         alu_gnt = g;
         a0 = alu_a;
         b0 = alu_b;
         @(posedge clk);
         #1;
         lat++;
         if (!g) begin
            rem_st--;
            chk("stall_alu_a", 64'(alu_a), 64'(a0));
            chk("stall_alu_b", 64'(alu_b), 64'(b0));
            chk("stall_no_done", 64'(res_valid), 64'd0);
         end else begin
            granted++;
         end
      end
      alu_gnt = 1'b1;
      chk("latency", 64'(lat), 64'(exp_lat));

      h0 = res_hi;
      l0 = res_lo;
      for (int i = 0; i < rr_hold; i++) begin
         @(negedge clk);
         res_ready = 1'b0;
         @(posedge clk);
         #1;
         chk("hold_res_valid", 64'(res_valid), 64'd1);
         chk("hold_res_hi", 64'(res_hi), 64'(h0));
         chk("hold_res_lo", 64'(res_lo), 64'(l0));
         chk("hold_start_ready", 64'(start_ready), 64'd0);
      end

      @(negedge clk);
      chk("done_alu_req", 64'(alu_req), 64'd0);
      chk("done_start_ready", 64'(start_ready), 64'd0);
      res_ready = 1'b1;
      if (sb.size() == 0) begin
         chk("sb_nonempty", 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         chk("res_valid", 64'(res_valid), 64'd1);
         chk("res_hi", 64'(res_hi), 64'(e.hi));
         chk("res_lo", 64'(res_lo), 64'(e.lo));
         chk("res_dz", 64'(res_dz), 64'(e.dz));
      end
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      chk("post_hs_valid", 64'(res_valid), 64'd0);
      chk("post_hs_ready", 64'(start_ready), 64'd1);
      chk("post_hs_hi_kept", 64'(res_hi), 64'(e.hi));
      chk("post_hs_lo_kept", 64'(res_lo), 64'(e.lo));
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      start_valid = 1'b0;
      start_op    = 1'b0;
      start_a     = '0;
      start_b     = '0;
      res_ready   = 1'b0;
      alu_gnt     = 1'b1;
      #22;
      chk_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;

      run_op(1'b0, 32'h0000_0007, 32'h0000_0006, 0, 0);
      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      run_op(1'b1, 32'd100, 32'd7, 0, 0);
      run_op(1'b1, 32'h8000_0001, 32'h8000_0000, 0, 0);
      run_op(1'b1, 32'h0000_1234, 32'd0, 0, 2);
      run_op(1'b0, 32'd3, 32'd5, 10, 5);
      for (int i = 0; i < 4; i++) begin
         run_op(1'(i), $urandom, $urandom_range(1, 32'hFFFF), i, i);
      end

      // Abort a divide at iteration 16 with an asynchronous reset
      @(negedge clk);
      start_valid = 1'b1;
      start_op    = 1'b1;
      start_a     = 32'd1000;
      start_b     = 32'd3;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      repeat (16) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals();
      @(posedge clk);
      #1;
      chk_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1'b1, 32'd9, 32'd2, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Iterative sequencer that performs 32x32 unsigned multiply (64-bit product) and 32/32 unsigned divide (quotient and remainder).
- It does this by driving the shared 32-bit ALU one operation per granted cycle.
- Sits beside the execute stage: it raises alu_req, and the execute-stage ALU mux hands it the ALU while alu_gnt is high.
- Start/result use valid/ready handshakes.

Parameters:
DIVZERO_Q, 32'hFFFFFFFF, quotient returned on divide by zero
ITERS, 32, number of iterations per operation; fixed to operand width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_valid  in  1  operation request
start_ready  out  1  high only in IDLE
start_op  in  1  0 = UMUL, 1 = UDIV
start_a  in  32  multiplicand / dividend
start_b  in  32  multiplier / divisor
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_hi  out  32  UMUL: product[63:32]; UDIV: remainder
res_lo  out  32  UMUL: product[31:0]; UDIV: quotient
res_dz  out  1  divide-by-zero indication
alu_req  out  1  sequencer wants the ALU (high in CALC)
alu_gnt  in  1  ALU granted this cycle
alu_op  out  4  ALU opcode: 4'b0000 add, 4'b0010 subtract
alu_a  out  32  ALU operand A
alu_b  out  32  ALU operand B
alu_cin  out  1  always 0
alu_y  in  32  ALU result
alu_flags  in  4  {Z,N,C,V}; add: C = carry-out; subtract: C = 1 iff a < b unsigned

Behaviour:
- Reset (async, rst_n low): state IDLE; start_ready=1; res_valid=0; res_hi=res_lo=0; res_dz=0; alu_req=0; alu_op=0; alu_a=alu_b=0; counter=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start_valid && start_ready latches op, operands and clears res_dz.
  - UDIV with start_b==0: go directly to DONE with res_lo=DIVZERO_Q, res_hi=start_a, res_dz=1. The ALU is never requested.
  - All other accepts: go to CALC, counter=0.
- CALC, UMUL. Internal regs: hi=0, lo=multiplier, mc=multiplicand.
  - alu_op=0000, alu_a=hi, alu_b = lo[0] ? mc : 0.
  - On a granted edge: {hi,lo} <= {alu_flags[1], alu_y, lo[31:1]}, i.e. the 65-bit value is shifted right 1.
- CALC, UDIV. Internal regs: r=0, q=dividend, d=divisor, t={r[30:0],q[31]}.
  - alu_op=0010, alu_a=t, alu_b=d.
  - On a granted edge: if r[31] || !alu_flags[1], then r<=alu_y and q<={q[30:0],1}; else r<=t and q<={q[30:0],0}.
- Iteration stepping and stalls:
  - Only edges with alu_gnt=1 advance state or the counter. alu_gnt=0 is a stall: all registers hold and ALU outputs stay stable.
  - alu_req=1 for every CALC cycle and 0 otherwise. ALU outputs are don't-care but driven to 0 outside CALC.
  - After the 32nd granted iteration: load res_hi/res_lo (UMUL {hi,lo}; UDIV {r,q}) and go to DONE.
- Latency: with continuous grant, res_valid rises 33 cycles after the accept edge. Each stall cycle adds one cycle.
- DONE:
  - res_valid=1; result outputs hold stable until res_valid && res_ready.
  - On that handshake: go to IDLE and res_valid=0. res_* keep their last value.
  - start_ready=0 in CALC and DONE, so there is no back-to-back accept in the same cycle as result hand-off. The next accept is possible the cycle after returning to IDLE.
- res_ready while not in DONE is ignored; start_valid outside IDLE is ignored.
- A start_* change after acceptance has no effect; operands are latched.
- rst_n asserted mid-CALC or mid-DONE aborts immediately to the reset values; the in-flight result is lost.

Test Plan:
- UMUL 32'h0000_0007 x 32'h0000_0006, alu_gnt=1, res_ready=1 -> res_valid 33 cycles after accept; res_hi=0, res_lo=32'h2A, res_dz=0.
- UMUL 32'hFFFF_FFFF x 32'hFFFF_FFFF -> res_hi=32'hFFFF_FFFE, res_lo=32'h0000_0001; checks carry capture through alu_flags[1].
- UDIV 32'd100 / 32'd7, then UDIV 32'h8000_0001 / 32'h8000_0000 -> first gives res_lo=14, res_hi=2; second gives res_lo=1, res_hi=1.
- UDIV 32'h1234 / 0 -> res_valid 1 cycle after accept; res_lo=32'hFFFF_FFFF, res_hi=32'h1234, res_dz=1; alu_req never high.
- UMUL 3x5 with alu_gnt low for 10 random CALC cycles and res_ready held low 5 cycles in DONE -> res_valid at cycle 43, result 15, outputs stable until res_ready, start_ready=0 throughout.
- Assert rst_n low at CALC iteration 16, release, issue UDIV 9/2 -> all outputs at reset values during reset; subsequent result res_lo=4, res_hi=1.
